cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single writeback/common data bus (CDB) between the functional units: ALU, load unit and store-address unit.
//  Each unit pushes (ROB tag, result, result2) into a private FIFO. One entry per cycle is granted onto a registered CDB.
//  The CDB feeds the ROB update port and the reservation-station/LSB wakeup logic.
//  Sits between the execute stage and the ROB.
// PARAMETERS
//  N_REQ    3   number of requesters (0=ALU, 1=load, 2=store)
//  TAG_W    5   ROB tag width (ROB_SZ_LOG+1)
//  DATA_W   32  result / result2 width
//  DEPTH    2   entries per requester FIFO (power of 2, >=2)
// PORTS
//  clk        in   1              clock
//  rst        in   1              synchronous active-high reset
//  rdy        in   1              global stall; low = freeze all state
//  flush      in   1              mispredict/JALR redirect; discard all pending results
//  req_valid  in   N_REQ          requester i offers an entry
//  req_ready  out  N_REQ          requester i FIFO can accept
//  req_tag    in   N_REQ*TAG_W    ROB tag per requester, slice i = [i*TAG_W +: TAG_W]
//  req_res    in   N_REQ*DATA_W   primary result per requester
//  req_res2   in   N_REQ*DATA_W   secondary result (branch/jump target) per requester
//  rob_head   in   TAG_W          current ROB head; used only with CDB_AGE_PRIO_EN
//  cdb_valid  out  1              broadcast valid this cycle
//  cdb_src    out  N_REQ          one-hot source of the broadcast
//  cdb_tag    out  TAG_W          ROB tag broadcast
//  cdb_res    out  DATA_W         primary result broadcast
//  cdb_res2   out  DATA_W         secondary result broadcast
//  pending    out  N_REQ*$clog2(DEPTH+1)  per-FIFO occupancy (debug/perf)
// BEHAVIOUR
//  - Priority of control: rst > ~rdy > flush > normal operation.
//  - Reset: all FIFOs empty; cdb_valid/cdb_src/cdb_tag/cdb_res/cdb_res2 = 0; pending = 0; rr_last = N_REQ-1, so requester 0 wins first.
//  - req_ready[i] = rdy & ~flush & (count[i] < DEPTH). Combinational from registered count; no full-FIFO bypass.
//  - Enqueue on edge where req_valid[i] & req_ready[i]; FIFO head/tail pointers wrap mod DEPTH.
//  - Each cycle: candidate set C = {i : count[i] != 0}, taken from pre-edge state.
//    The winner's head entry drives the CDB registers at the edge and is dequeued the same edge.
//    Same-cycle enqueue and dequeue on one FIFO is legal; count is unchanged.
//  - C empty: cdb_valid <= 0. Data/tag/src registers hold their value (don't-care when invalid).
//  - Latency: an entry accepted at edge T appears with cdb_valid=1 in the cycle after edge T+1 at the earliest.
//    An entry is never dropped except by flush/rst.
//  - Round robin: the search starts at (rr_last+1) mod N_REQ and rr_last <= winner.
//    A requester that is continuously non-empty is granted within N_REQ cycles.
//  - cdb_valid is a one-cycle pulse per entry. Back-to-back grants are allowed every cycle.
//  - ~rdy: all registers hold, including cdb_* (consumers are frozen by rdy too); req_ready = 0.
//  - flush: all counts <= 0; cdb_valid <= 0; rr_last <= N_REQ-1.
//    Same-cycle req_valid is ignored because req_ready is 0.
//  - rst asserted mid-operation: same as the reset state on the next edge, regardless of rdy.
// CONFIGURATION
//  CDB_AGE_PRIO_EN defined:
//    - Winner = candidate with the smallest age = (head_tag - rob_head) mod 2^TAG_W.
//    - Ties go to the lowest index. rr_last is still updated but unused.
//    - Starvation-free, because the ROB head always drains.
//  CDB_AGE_PRIO_EN undefined: pure round robin as above; rob_head is unused.
// TESTING
//  - Reset: rst=1 for 2 cycles -> cdb_valid=0, pending=0, req_ready=3'b111 once rst=0 and rdy=1.
//  - Single: req0 tag=5, res=32'hDEAD at edge T -> at T+1, cdb_valid=1, src=3'b001, tag=5, res=32'hDEAD; pending0=0.
//  - RR fairness: all three FIFOs held full -> grants in order src 001,010,100,001,...
//    req_ready toggles with each dequeue; no entry is lost over 30 cycles.
//  - Backpressure: ALU pushes 3 entries while load keeps winning -> req_ready[0]=0 after 2 pushes.
//    The third push is accepted the cycle after an ALU grant.
//  - Flush/stall: 4 entries pending, assert flush -> next cycle cdb_valid=0, pending=0.
//    With rdy=0, cdb_* and pending freeze; they resume on rdy=1.
//  - Age (CDB_AGE_PRIO_EN): rob_head=30, req0 tag=2, req1 tag=31 same cycle -> tag 31 broadcast first, then tag 2 (wrap).

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit result FIFOs sharing one registered common data bus.
// Ports: clk/rst (sync, active-high), rdy (global stall), flush (discard all),
//   req_valid/req_ready/req_tag/req_res/req_res2 (packed per requester),
//   rob_head (age priority only), cdb_valid/src/tag/res/res2, pending (occupancy).
// Option: define CDB_AGE_PRIO_EN to grant the entry closest to rob_head
//   instead of round robin.
module cdb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_res,
    input  logic [N_REQ*DATA_W-1:0]   req_res2,
    input  logic [TAG_W-1:0]          rob_head,
    output logic                      cdb_valid,
    output logic [N_REQ-1:0]          cdb_src,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_res,
    output logic [DATA_W-1:0]         cdb_res2,
    output logic [N_REQ*CNT_W-1:0]    pending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(N_REQ - 1);

    logic [CNT_W-1:0]  count_q   [N_REQ];
    logic [CNT_W-1:0]  count_d   [N_REQ];
    logic [PTR_W-1:0]  wr_ptr_q  [N_REQ];
    logic [PTR_W-1:0]  wr_ptr_d  [N_REQ];
    logic [PTR_W-1:0]  rd_ptr_q  [N_REQ];
    logic [PTR_W-1:0]  rd_ptr_d  [N_REQ];
    logic [TAG_W-1:0]  tag_mem_q [N_REQ][DEPTH];
    logic [TAG_W-1:0]  tag_mem_d [N_REQ][DEPTH];
    logic [DATA_W-1:0] res_mem_q [N_REQ][DEPTH];
    logic [DATA_W-1:0] res_mem_d [N_REQ][DEPTH];
    logic [DATA_W-1:0] res2_mem_q[N_REQ][DEPTH];
    logic [DATA_W-1:0] res2_mem_d[N_REQ][DEPTH];
    logic [IDX_W-1:0]  rr_last_q, rr_last_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [N_REQ-1:0]  cdb_src_q, cdb_src_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_res_q, cdb_res_d;
    logic [DATA_W-1:0] cdb_res2_q, cdb_res2_d;

    logic [N_REQ-1:0]  nonempty;
    logic              grant_any;
    logic [IDX_W-1:0]  win;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            nonempty[i]  = (count_q[i] != '0);
            req_ready[i] = rdy & ~flush & (count_q[i] < DEPTH_C);
            pending[i*CNT_W +: CNT_W] = count_q[i];
        end
    end

`ifdef CDB_AGE_PRIO_EN
    logic [TAG_W-1:0] age, best_age;

    // Age is distance from the ROB head; strict < keeps ties on lowest index.
    always_comb begin
        grant_any = 1'b0;
        win       = '0;
        age       = '0;
        best_age  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            age = tag_mem_q[i][rd_ptr_q[i]] - rob_head;
            if (nonempty[i] && (!grant_any || age < best_age)) begin
                grant_any = 1'b1;
                win       = IDX_W'(i);
                best_age  = age;
            end
        end
    end
`else
    logic unused_rob_head;
    assign unused_rob_head = ^rob_head;

    // Search starts one past the last winner.
    always_comb begin
        grant_any = 1'b0;
        win       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any && nonempty[(int'(rr_last_q) + 1 + k) % N_REQ]) begin
                grant_any = 1'b1;
                win       = IDX_W'((int'(rr_last_q) + 1 + k) % N_REQ);
            end
        end
    end
`endif

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_mem_d   = tag_mem_q;
        res_mem_d   = res_mem_q;
        res2_mem_d  = res2_mem_q;
        rr_last_d   = rr_last_q;
        cdb_valid_d = cdb_valid_q;
        cdb_src_d   = cdb_src_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_res_d   = cdb_res_q;
        cdb_res2_d  = cdb_res2_q;
        if (rdy) begin
            if (flush) begin
                for (int i = 0; i < N_REQ; i++) begin
                    count_d[i]  = '0;
                    wr_ptr_d[i] = '0;
                    rd_ptr_d[i] = '0;
                end
                cdb_valid_d = 1'b0;
                rr_last_d   = LAST_C;
            end else begin
                cdb_valid_d = grant_any;
                if (grant_any) begin
                    cdb_src_d    = N_REQ'(1) << win;
                    cdb_tag_d    = tag_mem_q[win][rd_ptr_q[win]];
                    cdb_res_d    = res_mem_q[win][rd_ptr_q[win]];
                    cdb_res2_d   = res2_mem_q[win][rd_ptr_q[win]];
                    rd_ptr_d[win] = rd_ptr_q[win] + PTR_W'(1);
                    rr_last_d    = win;
                end
                for (int i = 0; i < N_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        tag_mem_d[i][wr_ptr_q[i]]  = req_tag[i*TAG_W +: TAG_W];
                        res_mem_d[i][wr_ptr_q[i]]  = req_res[i*DATA_W +: DATA_W];
                        res2_mem_d[i][wr_ptr_q[i]] = req_res2[i*DATA_W +: DATA_W];
                        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
                    end
                    unique case ({req_valid[i] & req_ready[i],
                                  grant_any && (win == IDX_W'(i))})
                        2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                        2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                        default: count_d[i] = count_q[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            rr_last_q   <= LAST_C;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_res_q   <= '0;
            cdb_res2_q  <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_last_q   <= rr_last_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_res_q   <= cdb_res_d;
            cdb_res2_q  <= cdb_res2_d;
        end
    end

    // Payload storage needs no reset: occupancy alone marks entries live.
    always_ff @(posedge clk) begin
        tag_mem_q  <= tag_mem_d;
        res_mem_q  <= res_mem_d;
        res2_mem_q <= res2_mem_d;
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_src   = cdb_src_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_res   = cdb_res_q;
    assign cdb_res2  = cdb_res2_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter (default round-robin build).
// Covers reset, single entry, RR fairness, stall, flush, backpressure, reset.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic [2:0]  req_valid, req_ready;
    logic [14:0] req_tag;
    logic [95:0] req_res, req_res2;
    logic [4:0]  rob_head;
    logic        cdb_valid;
    logic [2:0]  cdb_src;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_res, cdb_res2;
    logic [5:0]  pending;

    int n_checks = 0;
    int n_fails  = 0;

    int push_seq[3];
    int pop_seq[3];
    int cnt_m[3];
    logic [2:0] ready_m;
    int w;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_res(req_res), .req_res2(req_res2),
        .rob_head(rob_head),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_tag(cdb_tag),
        .cdb_res(cdb_res), .cdb_res2(cdb_res2), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int i, input logic v, input logic [4:0] t,
                       input logic [31:0] r, input logic [31:0] r2);
        req_valid[i]        = v;
        req_tag[i*5 +: 5]   = t;
        req_res[i*32 +: 32] = r;
        req_res2[i*32 +: 32] = r2;
    endtask

    function automatic logic [4:0] tag_of(input int i, input int s);
        return 5'(i * 8 + (s % 8));
    endfunction

    function automatic logic [31:0] res_of(input int i, input int s);
        return 32'hA000_0000 | 32'(i << 16) | 32'(s);
    endfunction

    function automatic logic [31:0] pend_m();
        return 32'({2'(cnt_m[2]), 2'(cnt_m[1]), 2'(cnt_m[0])});
    endfunction

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        req_valid = '0; req_tag = '0; req_res = '0; req_res2 = '0;
        rob_head = '0;
        tick; tick;
        check("rst_valid", 32'(cdb_valid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_tag", 32'(cdb_tag), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 32'b111);

        // single entry
        drv(0, 1'b1, 5'd5, 32'hDEAD, 32'h1234);
        tick;
        drv(0, 1'b0, 5'd0, 32'd0, 32'd0);
        check("single_pend1", 32'(pending), 32'h1);
        check("single_nv", 32'(cdb_valid), 32'd0);
        tick;
        check("single_valid", 32'(cdb_valid), 32'd1);
        check("single_src", 32'(cdb_src), 32'b001);
        check("single_tag", 32'(cdb_tag), 32'd5);
        check("single_res", cdb_res, 32'hDEAD);
        check("single_res2", cdb_res2, 32'h1234);
        check("single_pend0", 32'(pending), 32'd0);
        tick;
        check("single_pulse", 32'(cdb_valid), 32'd0);
        check("single_hold", 32'(cdb_tag), 32'd5);

        // round robin with all three requesters kept busy
        for (int i = 0; i < 3; i++) begin
            push_seq[i] = 0; pop_seq[i] = 0; cnt_m[i] = 0;
            drv(i, 1'b1, tag_of(i, 0), res_of(i, 0), ~res_of(i, 0));
        end
        tick;
        for (int i = 0; i < 3; i++) begin
            push_seq[i] = 1; cnt_m[i] = 1;
            drv(i, 1'b1, tag_of(i, 1), res_of(i, 1), ~res_of(i, 1));
        end
        check("rr_first_nv", 32'(cdb_valid), 32'd0);
        check("rr_first_pend", 32'(pending), pend_m());
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 3; i++) ready_m[i] = (cnt_m[i] < 2);
            check("rr_ready", 32'(req_ready), 32'(ready_m));
            tick;
            w = (1 + k) % 3;
            for (int i = 0; i < 3; i++) begin
                if (ready_m[i]) begin
                    push_seq[i]++;
                    cnt_m[i]++;
                end
            end
            cnt_m[w]--;
            check("rr_valid", 32'(cdb_valid), 32'd1);
            check("rr_src", 32'(cdb_src), 32'(3'b001 << w));
            check("rr_tag", 32'(cdb_tag), 32'(tag_of(w, pop_seq[w])));
            check("rr_res", cdb_res, res_of(w, pop_seq[w]));
            check("rr_pend", 32'(pending), pend_m());
            pop_seq[w]++;
            for (int i = 0; i < 3; i++)
                drv(i, 1'b1, tag_of(i, push_seq[i]), res_of(i, push_seq[i]),
                    ~res_of(i, push_seq[i]));
        end
        req_valid = '0;

        // one more grant, then stall
        tick;
        cnt_m[1]--;
        check("drain_src", 32'(cdb_src), 32'b010);
        check("drain_tag", 32'(cdb_tag), 32'(tag_of(1, pop_seq[1])));
        pop_seq[1]++;
        rdy = 1'b0;
        #1;
        check("stall_ready", 32'(req_ready), 32'd0);
        tick; tick;
        check("stall_valid", 32'(cdb_valid), 32'd1);
        check("stall_src", 32'(cdb_src), 32'b010);
        check("stall_tag", 32'(cdb_tag), 32'(tag_of(1, pop_seq[1] - 1)));
        check("stall_pend", 32'(pending), pend_m());
        rdy = 1'b1;
        tick;
        cnt_m[2]--;
        check("resume_src", 32'(cdb_src), 32'b100);
        check("resume_tag", 32'(cdb_tag), 32'(tag_of(2, pop_seq[2])));
        check("resume_pend", 32'(pending), pend_m());

        // flush with entries pending; same-cycle push is ignored
        flush = 1'b1;
        drv(0, 1'b1, 5'd9, 32'h99, 32'h99);
        #1;
        check("flush_ready", 32'(req_ready), 32'd0);
        tick;
        flush = 1'b0;
        req_valid = '0;
        check("flush_valid", 32'(cdb_valid), 32'd0);
        check("flush_pend", 32'(pending), 32'd0);
        tick;
        check("flush_idle", 32'(cdb_valid), 32'd0);
        check("flush_pend2", 32'(pending), 32'd0);

        // backpressure on the ALU FIFO
        drv(1, 1'b1, 5'd8, 32'h108, 32'h0);
        drv(2, 1'b1, 5'd16, 32'h216, 32'h0);
        tick;
        drv(0, 1'b1, 5'd1, 32'h001, 32'h0);
        drv(1, 1'b1, 5'd9, 32'h109, 32'h0);
        drv(2, 1'b1, 5'd17, 32'h217, 32'h0);
        tick;
        check("bp_g1", 32'(cdb_tag), 32'd8);
        drv(0, 1'b1, 5'd2, 32'h002, 32'h0);
        drv(1, 1'b1, 5'd10, 32'h110, 32'h0);
        req_valid[2] = 1'b0;
        tick;
        check("bp_g2", 32'(cdb_tag), 32'd16);
        check("bp_full", 32'(req_ready[0]), 32'd0);
        check("bp_pend", 32'(pending), 32'b01_10_10);
        drv(0, 1'b1, 5'd3, 32'h003, 32'h0);
        req_valid[1] = 1'b0;
        tick;
        check("bp_alu_tag", 32'(cdb_tag), 32'd1);
        check("bp_alu_src", 32'(cdb_src), 32'b001);
        check("bp_reopen", 32'(req_ready[0]), 32'd1);
        tick;
        req_valid = '0;
        check("bp_g4", 32'(cdb_tag), 32'd9);
        check("bp_third", 32'(pending[1:0]), 32'd2);
        tick;
        check("bp_g5", 32'(cdb_tag), 32'd17);
        tick;
        check("bp_g6", 32'(cdb_tag), 32'd2);
        tick;
        check("bp_g7", 32'(cdb_tag), 32'd10);
        tick;
        check("bp_g8", 32'(cdb_tag), 32'd3);
        check("bp_g8_res", cdb_res, 32'h003);
        tick;
        check("bp_empty", 32'(cdb_valid), 32'd0);
        check("bp_pend0", 32'(pending), 32'd0);

`ifdef CDB_AGE_PRIO_EN
        rob_head = 5'd30;
        drv(0, 1'b1, 5'd2, 32'h2, 32'h0);
        drv(1, 1'b1, 5'd31, 32'h31, 32'h0);
        tick;
        req_valid = '0;
        tick;
        check("age_first", 32'(cdb_tag), 32'd31);
        tick;
        check("age_second", 32'(cdb_tag), 32'd2);
        tick;
`endif

        // reset mid-operation, even while stalled
        drv(2, 1'b1, 5'd7, 32'h77, 32'h0);
        tick;
        tick;
        req_valid = '0;
        check("pre_rst_tag", 32'(cdb_tag), 32'd7);
        rdy = 1'b0;
        rst = 1'b1;
        tick;
        check("mid_rst_valid", 32'(cdb_valid), 32'd0);
        check("mid_rst_tag", 32'(cdb_tag), 32'd0);
        check("mid_rst_src", 32'(cdb_src), 32'd0);
        check("mid_rst_pend", 32'(pending), 32'd0);
        rst = 1'b0;
        rdy = 1'b1;
        tick;
        check("post_rst_valid", 32'(cdb_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
